// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums per-channel-group psum beats of one output tile and
// streams the final OFM values on port0/port1. Define PSUM_SAT_EN for saturating adds.
module psum_accum #(
    parameter int PSUM_WIDTH = 20,
    parameter int OFM_WIDTH  = 25,
    parameter int TILE_W_MAX = 16,
    parameter int PAIRS      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            ic_groups,
    input  logic [7:0]            tile_w,
    input  logic                  in_v,
    input  logic [PSUM_WIDTH-1:0] in_row0,
    input  logic [PSUM_WIDTH-1:0] in_row1,
    input  logic                  in_row1_v,
    output logic                  port0_v,
    output logic                  port1_v,
    output logic [OFM_WIDTH-1:0]  port0,
    output logic [OFM_WIDTH-1:0]  port1,
    output logic                  busy,
    output logic                  tile_done,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int DEPTH  = PAIRS * TILE_W_MAX;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [7:0] TW_MAX = 8'(TILE_W_MAX);
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(PAIRS - 1);
    localparam logic [OFM_WIDTH-1:0] OFM_MAX = {1'b0, {(OFM_WIDTH-1){1'b1}}};
    localparam logic [OFM_WIDTH-1:0] OFM_MIN = {1'b1, {(OFM_WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_LAST  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [7:0]            col_q, col_d;
    logic [PAIR_W-1:0]     pair_q, pair_d;
    logic [7:0]            pass_q, pass_d;
    logic [7:0]            ic_groups_q, ic_groups_d;
    logic [7:0]            tile_w_q, tile_w_d;
    logic                  err_q, err_d;
    logic                  port0_v_q, port0_v_d;
    logic                  port1_v_q, port1_v_d;
    logic [OFM_WIDTH-1:0]  port0_q, port0_d;
    logic [OFM_WIDTH-1:0]  port1_q, port1_d;
    logic                  tile_done_q, tile_done_d;

    logic [OFM_WIDTH-1:0]  buf0_q [DEPTH];
    logic [OFM_WIDTH-1:0]  buf1_q [DEPTH];
    logic                  wr0_en, wr1_en;
    logic [OFM_WIDTH-1:0]  wr0_data, wr1_data;

    logic [ADDR_W-1:0]     addr;
    logic [OFM_WIDTH-1:0]  ext0, ext1, sum0, sum1;
    logic [7:0]            ic_eff, tw_eff;
    logic                  beat, last_col, last_pair, end_pass, first_pass;

    function automatic logic [OFM_WIDTH-1:0] add_fn(input logic [OFM_WIDTH-1:0] a,
                                                    input logic [OFM_WIDTH-1:0] b);
        logic [OFM_WIDTH:0] s;
        s = {a[OFM_WIDTH-1], a} + {b[OFM_WIDTH-1], b};
`ifdef PSUM_SAT_EN
        if (s[OFM_WIDTH] != s[OFM_WIDTH-1])
            add_fn = s[OFM_WIDTH] ? OFM_MIN : OFM_MAX;
        else
            add_fn = s[OFM_WIDTH-1:0];
`else
        add_fn = s[OFM_WIDTH-1:0];
`endif
    endfunction

    assign ic_eff = (ic_groups == 8'd0) ? 8'd1 : ic_groups;
    assign tw_eff = (tile_w == 8'd0) ? 8'd1 : ((tile_w > TW_MAX) ? TW_MAX : tile_w);

    // A start in the same cycle as in_v always wins; the beat is discarded.
    assign beat       = in_v && !start && (state_q != S_IDLE);
    assign last_col   = (col_q == tile_w_q - 8'd1);
    assign last_pair  = (pair_q == PAIR_LAST);
    assign end_pass   = beat && last_col && last_pair;
    assign first_pass = (pass_q == 8'd0);

    assign addr = ADDR_W'(pair_q) * ADDR_W'(TILE_W_MAX) + ADDR_W'(col_q);
    assign ext0 = OFM_WIDTH'($signed(in_row0));
    assign ext1 = OFM_WIDTH'($signed(in_row1));
    assign sum0 = add_fn(buf0_q[addr], ext0);
    assign sum1 = add_fn(buf1_q[addr], ext1);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        pair_d      = pair_q;
        pass_d      = pass_q;
        ic_groups_d = ic_groups_q;
        tile_w_d    = tile_w_q;
        err_d       = err_q;
        port0_v_d   = 1'b0;
        port1_v_d   = 1'b0;
        port0_d     = port0_q;
        port1_d     = port1_q;
        tile_done_d = 1'b0;
        wr0_en      = 1'b0;
        wr1_en      = 1'b0;
        wr0_data    = first_pass ? ext0 : sum0;
        wr1_data    = first_pass ? ext1 : sum1;

        if (start) begin
            ic_groups_d = ic_eff;
            tile_w_d    = tw_eff;
            col_d       = 8'd0;
            pair_d      = '0;
            pass_d      = 8'd0;
            state_d     = (ic_eff == 8'd1) ? S_LAST : S_ACCUM;
            err_d       = (state_q == S_IDLE) && in_v;
        end else begin
            if (in_v && (state_q == S_IDLE))
                err_d = 1'b1;
            if (beat) begin
                if (last_col) begin
                    col_d = 8'd0;
                    if (last_pair) begin
                        pair_d = '0;
                        pass_d = pass_q + 8'd1;
                    end else begin
                        pair_d = pair_q + PAIR_W'(1);
                    end
                end else begin
                    col_d = col_q + 8'd1;
                end

                if (state_q == S_ACCUM) begin
                    wr0_en = 1'b1;
                    wr1_en = in_row1_v;
                    if (end_pass && (pass_q == ic_groups_q - 8'd2))
                        state_d = S_LAST;
                end else begin
                    // Final pass reads the buffer but never writes it back.
                    port0_v_d = 1'b1;
                    port1_v_d = in_row1_v;
                    port0_d   = (ic_groups_q == 8'd1) ? ext0 : sum0;
                    if (in_row1_v)
                        port1_d = (ic_groups_q == 8'd1) ? ext1 : sum1;
                    if (end_pass) begin
                        state_d     = S_IDLE;
                        tile_done_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= 8'd0;
            pair_q      <= '0;
            pass_q      <= 8'd0;
            ic_groups_q <= 8'd1;
            tile_w_q    <= 8'd1;
            err_q       <= 1'b0;
            port0_v_q   <= 1'b0;
            port1_v_q   <= 1'b0;
            port0_q     <= '0;
            port1_q     <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            pair_q      <= pair_d;
            pass_q      <= pass_d;
            ic_groups_q <= ic_groups_d;
            tile_w_q    <= tile_w_d;
            err_q       <= err_d;
            port0_v_q   <= port0_v_d;
            port1_v_q   <= port1_v_d;
            port0_q     <= port0_d;
            port1_q     <= port1_d;
            tile_done_q <= tile_done_d;
        end
    end

    // Buffer contents are never reset; pass 0 always overwrites before any read.
    always_ff @(posedge clk) begin
        if (wr0_en)
            buf0_q[addr] <= wr0_data;
        if (wr1_en)
            buf1_q[addr] <= wr1_data;
    end

    assign port0_v   = port0_v_q;
    assign port1_v   = port1_v_q;
    assign port0     = port0_q;
    assign port1     = port1_q;
    assign busy      = (state_q != S_IDLE);
    assign tile_done = tile_done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: directed tiles on a default-width instance and a 20-bit-OFM
// instance sharing the same stimulus; expected outputs queued, checked by a monitor.
module tb_psum_accum;

    localparam int PW  = 20;
    localparam int OW  = 25;
    localparam int OWS = 20;

    // Valid/ready: there is no ready; every cycle with port0_v high is one output beat.
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [7:0]     ic_groups = 8'd0;
    logic [7:0]     tile_w = 8'd0;
    logic           in_v = 1'b0;
    logic [PW-1:0]  in_row0 = '0;
    logic [PW-1:0]  in_row1 = '0;
    logic           in_row1_v = 1'b0;

    logic           port0_v, port1_v, busy, tile_done, err;
    logic [OW-1:0]  port0, port1;
    logic [1:0]     state_dbg;
    logic           s_port0_v, s_port1_v, s_busy, s_tile_done, s_err;
    logic [OWS-1:0] s_port0, s_port1;
    logic [1:0]     s_state_dbg;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int tiles_exp = 0;

    logic [2*OW+1:0]  exp_q[$];
    logic [2*OWS+1:0] exp_s_q[$];

    psum_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ic_groups(ic_groups), .tile_w(tile_w),
        .in_v(in_v), .in_row0(in_row0), .in_row1(in_row1), .in_row1_v(in_row1_v),
        .port0_v(port0_v), .port1_v(port1_v), .port0(port0), .port1(port1),
        .busy(busy), .tile_done(tile_done), .err(err), .state_dbg(state_dbg)
    );

    psum_accum #(.OFM_WIDTH(OWS)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .ic_groups(ic_groups), .tile_w(tile_w),
        .in_v(in_v), .in_row0(in_row0), .in_row1(in_row1), .in_row1_v(in_row1_v),
        .port0_v(s_port0_v), .port1_v(s_port1_v), .port0(s_port0), .port1(s_port1),
        .busy(s_busy), .tile_done(s_tile_done), .err(s_err), .state_dbg(s_state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push2(input logic p1v, input int e0, input int e1,
                         input int s0, input int s1, input logic done);
        exp_q.push_back({done, p1v, OW'(e1), OW'(e0)});
        exp_s_q.push_back({done, p1v, OWS'(s1), OWS'(s0)});
    endtask

    task automatic push(input logic p1v, input int e0, input int e1, input logic done);
        push2(p1v, e0, e1, e0, e1, done);
    endtask

    // ---------------- driver tasks (entered and left at posedge + 1) ----------------
    task automatic do_start(input int icg, input int tw);
        start = 1'b1;
        ic_groups = 8'(icg);
        tile_w = 8'(tw);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic beat(input int r0, input int r1, input logic r1v);
        in_v = 1'b1;
        in_row0 = PW'(r0);
        in_row1 = PW'(r1);
        in_row1_v = r1v;
        @(posedge clk); #1;
        in_v = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [2*OW+1:0]  e;
        logic [2*OWS+1:0] es;
        if (rst_n) begin
            if (tile_done) done_cnt++;
            if (port0_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: port0=%0h with nothing expected at %0t", port0, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("port0", port0, e[OW-1:0]);
                    chk("port1_v", port1_v, e[2*OW]);
                    if (e[2*OW]) chk("port1", port1, e[2*OW-1:OW]);
                    chk("tile_done", tile_done, e[2*OW+1]);
                    if (e[2*OW+1]) chk("busy_at_done", busy, 0);
                end
            end else if (port1_v || tile_done) begin
                checks++;
                errors++;
                $display("FAIL stray_valid: port1_v=%0b tile_done=%0b required 0 at %0t", port1_v, tile_done, $time);
            end
            if (s_port0_v) begin
                if (exp_s_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_s: port0=%0h with nothing expected at %0t", s_port0, $time);
                end else begin
                    es = exp_s_q.pop_front();
                    chk("s_port0", s_port0, es[OWS-1:0]);
                    chk("s_port1_v", s_port1_v, es[2*OWS]);
                    if (es[2*OWS]) chk("s_port1", s_port1, es[2*OWS-1:OWS]);
                    chk("s_tile_done", s_tile_done, es[2*OWS+1]);
                end
            end else if (s_port1_v || s_tile_done) begin
                checks++;
                errors++;
                $display("FAIL stray_valid_s: port1_v=%0b tile_done=%0b required 0 at %0t", s_port1_v, s_tile_done, $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int v, e1, r1;
        logic r1v;

        // Reset values
        idle(2);
        chk("rst_port0_v", port0_v, 0);
        chk("rst_port1_v", port1_v, 0);
        chk("rst_port0", port0, 0);
        chk("rst_port1", port1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tile_done", tile_done, 0);
        chk("rst_err", err, 0);
        chk("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        idle(1);

        // Single pass: outputs equal inputs, done with the 12th
        do_start(1, 4);
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 4; c++) begin
                push(1'b1, c, 100 + c, (p == 2) && (c == 3));
                beat(c, 100 + c, 1'b1);
            end
        tiles_exp++;
        idle(2);
        chk("busy_after_tile", busy, 0);
        chk("state_after_tile", state_dbg, 0);

        // Three passes of 5: silent for two passes, then 15 everywhere
        do_start(3, 2);
        repeat (12) beat(5, 5, 1'b1);
        chk("state_last", state_dbg, 2);
        for (int i = 0; i < 6; i++) begin
            push(1'b1, 15, 15, i == 5);
            beat(5, 5, 1'b1);
        end
        tiles_exp++;
        idle(2);

        // Single-row beats on pair 2, negative lane-1 data
        do_start(3, 2);
        for (int ps = 0; ps < 3; ps++)
            for (int p = 0; p < 3; p++)
                for (int c = 0; c < 2; c++) begin
                    v = 10 * p + c + 1;
                    r1v = 1'b1;
                    r1 = -v;
                    if (ps == 1 && p == 2) begin r1v = 1'b0; r1 = 999; end
                    if (ps == 2 && p == 2 && c == 1) begin r1v = 1'b0; r1 = 555; end
                    if (ps == 2) begin
                        e1 = (p == 2) ? -2 * v : -3 * v;
                        push(r1v, 3 * v, e1, (p == 2) && (c == 1));
                    end
                    beat(v, r1, r1v);
                end
        tiles_exp++;
        idle(2);

        // ic_groups 0 acts as 1; tile_w 20 clamps to 16 (48 beats)
        do_start(0, 20);
        chk("ic0_enters_last", state_dbg, 2);
        for (int k = 0; k < 48; k++) begin
            push(1'b1, k, -k, k == 47);
            beat(k, -k, 1'b1);
        end
        tiles_exp++;
        idle(2);

        // Overflow on the 20-bit instance; tile_w 0 acts as 1 (3 beats per pass)
        do_start(2, 0);
        repeat (3) beat(524287, -524288, 1'b1);
        for (int i = 0; i < 3; i++) begin
`ifdef PSUM_SAT_EN
            push2(1'b1, 1048574, -1048576, 524287, -524288, i == 2);
`else
            push2(1'b1, 1048574, -1048576, -2, 0, i == 2);
`endif
            beat(524287, -524288, 1'b1);
        end
        tiles_exp++;
        idle(2);

        // Abort mid pass 1, restart with a beat in the start cycle, clean tile of 7
        do_start(2, 2);
        repeat (6) beat(3, 3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            push(1'b1, 6, 6, 1'b0);
            beat(3, 3, 1'b1);
        end
        start = 1'b1;
        in_v = 1'b1;
        in_row0 = PW'(12345);
        in_row1 = PW'(12345);
        ic_groups = 8'd2;
        tile_w = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        in_v = 1'b0;
        chk("err_restart_busy", err, 0);
        chk("busy_restart", busy, 1);
        chk("state_restart", state_dbg, 1);
        repeat (6) beat(7, 7, 1'b1);
        for (int i = 0; i < 6; i++) begin
            push(1'b1, 14, 14, i == 5);
            beat(7, 7, 1'b1);
        end
        tiles_exp++;
        idle(2);

        // in_v while idle sets err; start clears it
        beat(1, 1, 1'b1);
        chk("err_set", err, 1);
        chk("busy_err", busy, 0);
        do_start(1, 2);
        chk("err_cleared", err, 0);

        // Asynchronous reset in the middle of LAST
        for (int i = 0; i < 3; i++) begin
            push(1'b1, i + 1, i + 2, 1'b0);
            beat(i + 1, i + 2, 1'b1);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_port0_v", port0_v, 0);
        chk("arst_port1_v", port1_v, 0);
        chk("arst_port0", port0, 0);
        chk("arst_port1", port1, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tile_done", tile_done, 0);
        chk("arst_err", err, 0);
        chk("arst_state", state_dbg, 0);
        chk("arst_state_s", s_state_dbg, 0);
        chk("arst_busy_s", s_busy, 0);
        chk("arst_err_s", s_err, 0);
        chk("arst_queue_empty", exp_q.size(), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(1);

        // Recovery tile after reset
        do_start(1, 1);
        for (int i = 0; i < 3; i++) begin
            push(1'b1, -7 * (i + 1), 40 + i, i == 2);
            beat(-7 * (i + 1), 40 + i, 1'b1);
        end
        tiles_exp++;
        idle(3);

        // Final report
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp_s_q_drained", exp_s_q.size(), 0);
        chk("tile_done_count", done_cnt, tiles_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
